// File: rtl/npu_cu_pkg.sv
// npu_cu_pkg
//   Shared definitions for the NPU control unit: field widths, bit positions
//   of the instruction fields, tag/opcode/func encodings, the packed view of
//   an instruction and the packed bundle of decoded outputs.
//   Optional feature macro used by the decoder: ILLEGAL_CHECK_EN.
package npu_cu_pkg;

    localparam int ADDR_W  = 22;                 // address/register operand width
    localparam int RES_W   = ADDR_W / 2;         // resize operand width
    localparam int TAG_W   = 4;
    localparam int OPC_W   = 6;
    localparam int FUNC_W  = 10;
    localparam int INSTR_W = TAG_W + OPC_W + FUNC_W + 2 * ADDR_W;  // 64

    // Bit positions (LSB) of each field inside the instruction word
    localparam int TAG_LSB  = 60;
    localparam int OPC_LSB  = 54;
    localparam int FUNC_LSB = 44;
    localparam int OPA_LSB  = 22;
    localparam int OPB_LSB  = 0;

    localparam logic [TAG_W-1:0]  TAG_NPU   = 4'b0001;
    localparam logic [OPC_W-1:0]  OP_LDST   = 6'd0;
    localparam logic [OPC_W-1:0]  OP_RESIZE = 6'd1;
    localparam logic [FUNC_W-1:0] FN_LOAD   = 10'd0;
    localparam logic [FUNC_W-1:0] FN_STORE  = 10'd1;

    // Packed view of the instruction word; member order matches bit order
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [OPC_W-1:0]  opcode;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] op_a;
        logic [ADDR_W-1:0] op_b;
    } instr_t;

    // Everything the decoder produces for one instruction
    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] store_or_load_address;
        logic [ADDR_W-1:0] data_register_or_address;
        logic [ADDR_W-1:0] image_buffer_register;
        logic [RES_W-1:0]  resize_reg_1;
        logic [RES_W-1:0]  resize_reg_2;
        logic              is_load;
        logic              is_store;
        logic              is_resize;
        logic              illegal;
    } decode_t;

endpackage

// File: rtl/npu_control_unit_if.sv
// npu_control_unit_if
//   Bundles the instruction input and the decoded outputs of the control unit.
//   Signals:
//     instr_valid, instruction            fetch -> control unit
//     out_valid, opcode, func, operand
//     fields and class flags              control unit -> execution units
//   Modports: master (fetch/consumer side), slave (control unit).
//
//   Handshake: instr_valid is a one-way strobe with no ready. Every cycle in
//   which instr_valid is high at the rising edge transfers exactly one
//   instruction; the decode appears one cycle later qualified by a one-cycle
//   out_valid pulse. The consumer cannot stall the unit.
interface npu_control_unit_if;
    import npu_cu_pkg::*;

    logic                 instr_valid;
    logic [INSTR_W-1:0]   instruction;

    logic                 out_valid;
    logic [OPC_W-1:0]     opcode;
    logic [FUNC_W-1:0]    func;
    logic [ADDR_W-1:0]    Store_or_load_address;
    logic [ADDR_W-1:0]    Data_register_or_address;
    logic [ADDR_W-1:0]    Image_Buffer_Register;
    logic [RES_W-1:0]     Resize_Reg_1;
    logic [RES_W-1:0]     Resize_Reg_2;
    logic                 is_load;
    logic                 is_store;
    logic                 is_resize;
    logic                 illegal;

    modport master (
        output instr_valid, instruction,
        input  out_valid, opcode, func,
               Store_or_load_address, Data_register_or_address,
               Image_Buffer_Register, Resize_Reg_1, Resize_Reg_2,
               is_load, is_store, is_resize, illegal
    );

    modport slave (
        input  instr_valid, instruction,
        output out_valid, opcode, func,
               Store_or_load_address, Data_register_or_address,
               Image_Buffer_Register, Resize_Reg_1, Resize_Reg_2,
               is_load, is_store, is_resize, illegal
    );

endinterface

// File: rtl/npu_cu_field_decode.sv
// npu_cu_field_decode
//   Purely combinational split of a 64-bit instruction into its fields and
//   decode of the instruction class (load/store or resize).
//   Ports:
//     instruction  in   INSTR_W  raw instruction word
//     dec          out  decode_t decoded fields and flags
//   Macro ILLEGAL_CHECK_EN: when defined, tag and opcode are validated and
//   rejected instructions raise illegal with zeroed operands. When undefined,
//   the tag is ignored and every non-zero opcode decodes as resize.
module npu_cu_field_decode
    import npu_cu_pkg::*;
(
    input  logic [INSTR_W-1:0] instruction,
    output decode_t            dec
);

    instr_t f;
    logic   legal;

    assign f = instr_t'(instruction);

`ifdef ILLEGAL_CHECK_EN
    assign legal = (f.tag == TAG_NPU) &&
                   ((f.opcode == OP_LDST) || (f.opcode == OP_RESIZE));
`else
    // Tag is not inspected in this build
    logic unused_tag;
    assign unused_tag = ^f.tag;
    assign legal      = 1'b1;
`endif

    always_comb begin
        // Fields of the class not being decoded stay zero
        dec         = '0;
        dec.opcode  = f.opcode;
        dec.func    = f.func;
        dec.illegal = !legal;
        if (legal) begin
            if (f.opcode == OP_LDST) begin
                dec.store_or_load_address    = f.op_a;
                dec.data_register_or_address = f.op_b;
                // Unknown func: operands still delivered, no flag raised
                dec.is_load  = (f.func == FN_LOAD);
                dec.is_store = (f.func == FN_STORE);
            end else begin
                // With the check enabled only OP_RESIZE reaches here
                dec.image_buffer_register = f.op_a;
                dec.resize_reg_1          = f.op_b[2*RES_W-1:RES_W];
                dec.resize_reg_2          = f.op_b[RES_W-1:0];
                dec.is_resize             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_control_unit.sv
// npu_control_unit
//   Registered instruction decoder sitting between instruction fetch and the
//   load/store and image-resize execution units. One instruction per clock,
//   one cycle of latency, no backpressure.
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous active-high reset; clears every output
//     cu    npu_control_unit_if.slave: instr_valid/instruction in,
//           out_valid, opcode, func, operand fields and class flags out
//   Macro ILLEGAL_CHECK_EN: enables tag/opcode validation in the decoder.
//   Outputs hold their last decode while instr_valid is low; only out_valid
//   drops.
module npu_control_unit
    import npu_cu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    npu_control_unit_if.slave cu
);

    decode_t dec;
    decode_t dec_q;
    logic    out_valid_q;

    npu_cu_field_decode u_field_decode (
        .instruction (cu.instruction),
        .dec         (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= cu.instr_valid;
            if (cu.instr_valid) begin
                dec_q <= dec;
            end
        end
    end

    assign cu.out_valid                = out_valid_q;
    assign cu.opcode                   = dec_q.opcode;
    assign cu.func                     = dec_q.func;
    assign cu.Store_or_load_address    = dec_q.store_or_load_address;
    assign cu.Data_register_or_address = dec_q.data_register_or_address;
    assign cu.Image_Buffer_Register    = dec_q.image_buffer_register;
    assign cu.Resize_Reg_1             = dec_q.resize_reg_1;
    assign cu.Resize_Reg_2             = dec_q.resize_reg_2;
    assign cu.is_load                  = dec_q.is_load;
    assign cu.is_store                 = dec_q.is_store;
    assign cu.is_resize                = dec_q.is_resize;
    assign cu.illegal                  = dec_q.illegal;

endmodule

// File: tb/tb_npu_control_unit.sv
// tb_npu_control_unit
//   Bench for npu_control_unit. Expected decodes come from a constant table
//   for the directed cases and from a small independent reference function
//   for random instructions. Honours ILLEGAL_CHECK_EN the same way the design
//   does.
module tb_npu_control_unit;
    import npu_cu_pkg::*;

    localparam int EW = OPC_W + FUNC_W + 3 * ADDR_W + 2 * RES_W + 4;  // 108

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npu_control_unit_if cu_if ();

    npu_control_unit dut (
        .clk (clk),
        .rst (rst),
        .cu  (cu_if)
    );

    // ---------------- helpers ----------------
    typedef struct {
        logic [63:0]   instr;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t          tbl [8];
    logic [EW-1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          sb_valid;

    function automatic logic [EW-1:0] pack_exp(
        input logic [5:0]  op,  input logic [9:0] fn,
        input logic [21:0] sla, input logic [21:0] dra, input logic [21:0] ibr,
        input logic [10:0] r1,  input logic [10:0] r2,
        input logic ld, input logic st, input logic rs, input logic il);
        return {op, fn, sla, dra, ibr, r1, r2, ld, st, rs, il};
    endfunction

    function automatic logic [EW-1:0] dut_out();
        return {cu_if.opcode, cu_if.func, cu_if.Store_or_load_address,
                cu_if.Data_register_or_address, cu_if.Image_Buffer_Register,
                cu_if.Resize_Reg_1, cu_if.Resize_Reg_2, cu_if.is_load,
                cu_if.is_store, cu_if.is_resize, cu_if.illegal};
    endfunction

    // Reference decode written from the field layout
    function automatic logic [EW-1:0] ref_model(input logic [63:0] w);
        logic [3:0]  tag;
        logic [5:0]  op;
        logic [9:0]  fn;
        logic [21:0] a;
        logic [21:0] b;
        logic        bad;
        tag = w[63:60];
        op  = w[59:54];
        fn  = w[53:44];
        a   = w[43:22];
        b   = w[21:0];
`ifdef ILLEGAL_CHECK_EN
        bad = (tag != 4'b0001) || (op > 6'd1);
`else
        bad = 1'b0;
`endif
        if (bad)
            return pack_exp(op, fn, 22'd0, 22'd0, 22'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        else if (op == 6'd0)
            return pack_exp(op, fn, a, b, 22'd0, 11'd0, 11'd0, fn == 10'd0, fn == 10'd1, 1'b0, 1'b0);
        else
            return pack_exp(op, fn, 22'd0, 22'd0, a, b[21:11], b[10:0], 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [EW:0] act, input logic [EW:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [63:0] w, input logic [EW-1:0] e);
        @(posedge clk);
        #1;
        cu_if.instr_valid = 1'b1;
        cu_if.instruction = w;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cu_if.instr_valid = 1'b0;
            cu_if.instruction = {$urandom, $urandom};  // must be ignored
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk or posedge rst) begin
        if (rst) sb_valid <= 1'b0;
        else     sb_valid <= cu_if.instr_valid;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", {{EW{1'b0}}, cu_if.out_valid}, {{EW{1'b0}}, sb_valid});
            if (cu_if.out_valid && sb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", {{EW{1'b0}}, 1'b1}, {(EW+1){1'b0}});
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("decode", {1'b0, dut_out()}, {1'b0, e});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cu_if.instr_valid = 1'b0;
        cu_if.instruction = '0;

        tbl[0] = '{64'h1000000012000048, pack_exp(6'd0, 10'd0, 22'h48, 22'h48, 22'd0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[1] = '{64'h1000100012000048, pack_exp(6'd0, 10'd1, 22'h48, 22'h48, 22'd0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0)};
        tbl[2] = '{64'h1040000012000802, pack_exp(6'd1, 10'd0, 22'd0, 22'd0, 22'h48, 11'd1, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0)};
        tbl[3] = '{64'h1040100012000802, pack_exp(6'd1, 10'd1, 22'd0, 22'd0, 22'h48, 11'd1, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0)};
`ifdef ILLEGAL_CHECK_EN
        tbl[4] = '{64'h2000000012000048, pack_exp(6'd0, 10'd0, 22'd0, 22'd0, 22'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tbl[5] = '{64'h1140000012000802, pack_exp(6'd5, 10'd0, 22'd0, 22'd0, 22'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1)};
`else
        tbl[4] = '{64'h2000000012000048, pack_exp(6'd0, 10'd0, 22'h48, 22'h48, 22'd0, 11'd0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0)};
        tbl[5] = '{64'h1140000012000802, pack_exp(6'd5, 10'd0, 22'd0, 22'd0, 22'h48, 11'd1, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0)};
`endif
        // load/store class with an unknown func: operands delivered, no flag
        tbl[6] = '{64'h1000700012000048, pack_exp(6'd0, 10'd7, 22'h48, 22'h48, 22'd0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0)};
        // resize with all operand bits set
        tbl[7] = '{64'h107FFFFFFFFFFFFF, pack_exp(6'd1, 10'h3FF, 22'd0, 22'd0, 22'h3FFFFF, 11'h7FF, 11'h7FF, 1'b0, 1'b0, 1'b1, 1'b0)};

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1 chk("reset_state", {cu_if.out_valid, dut_out()}, {(EW+1){1'b0}});

        // table vectors, each followed by idle cycles to check hold
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].instr, tbl[i].exp);
            idle(2);
            @(negedge clk);
            #1 chk("hold", {cu_if.out_valid, dut_out()}, {1'b0, tbl[i].exp});
        end

        // back-to-back table vectors
        for (int i = 0; i < 8; i++) drive(tbl[i].instr, tbl[i].exp);
        idle(2);

        // random instructions with random gaps
        for (int i = 0; i < 40; i++) begin
            logic [63:0] w;
            w = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) w[63:60] = 4'b0001;
            case ($urandom_range(0, 2))
                0: w[59:54] = 6'd0;
                1: w[59:54] = 6'd1;
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0: w[53:44] = 10'd0;
                1: w[53:44] = 10'd1;
                default: ;
            endcase
            drive(w, ref_model(w));
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
        end
        idle(2);

        // reset pulse in the middle of a back-to-back stream
        for (int i = 0; i < 4; i++) drive(tbl[i].instr, tbl[i].exp);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cu_if.instr_valid = 1'b0;
        exp_q.delete();
        #1 chk("rst_async_clear", {cu_if.out_valid, dut_out()}, {(EW+1){1'b0}});
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        @(negedge clk);
        #1 chk("post_rst_zero", {cu_if.out_valid, dut_out()}, {(EW+1){1'b0}});
        drive(tbl[2].instr, tbl[2].exp);
        idle(2);
        @(negedge clk);
        #1 chk("post_rst_decode", {cu_if.out_valid, dut_out()}, {1'b0, tbl[2].exp});

        // every pushed expectation must have been consumed
        idle(2);
        chk("sb_drain", (EW+1)'(exp_q.size()), {(EW+1){1'b0}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
